// File: rtl/scr1_led_pwm_ctrl.sv
// scr1_led_pwm_ctrl: multi-channel status-LED driver with PWM, blink and breathe modes
// plus the board heartbeat; config goes to shadows and is applied at PWM period boundaries.
module scr1_led_pwm_ctrl #(
    parameter int CLK_FREQ    = 25000000,
    parameter int PWM_FREQ    = 1000,
    parameter int HB_HZ       = 1,
    parameter int BREATHE_DIV = 4,
    parameter int CH_NUM      = 12,
    localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [7:0]        cfg_duty,
    output logic [CH_NUM-1:0] led_o,
    output logic              heartbeat_o,
    output logic              pwm_period_o
);
    localparam int STEP_RAW = CLK_FREQ / (PWM_FREQ * 256);
    localparam int STEP_DIV = (STEP_RAW > 1) ? STEP_RAW : 1;
    localparam int HB_HALF  = CLK_FREQ / (2 * HB_HZ);
    localparam logic [1:0] M_OFF = 2'd0, M_PWM = 2'd1, M_BLINK = 2'd2;

    logic [31:0] step_cnt, hb_cnt, brth_cnt;
    logic [7:0]  pwm_cnt, breathe_lvl;
    logic        breathe_up, step_tick, boundary;
    logic [1:0]  sh_mode  [CH_NUM];
    logic [1:0]  act_mode [CH_NUM];
    logic [7:0]  sh_duty  [CH_NUM];
    logic [7:0]  act_duty [CH_NUM];
    logic [7:0]  duty_eff [CH_NUM];

    always_comb begin
        step_tick = step_cnt == 32'd0;
        boundary  = step_tick && pwm_cnt == 8'hff;
        for (int i = 0; i < CH_NUM; i++)
            duty_eff[i] = act_mode[i] == M_OFF   ? 8'd0 :
                          act_mode[i] == M_PWM   ? act_duty[i] :
                          act_mode[i] == M_BLINK ? (heartbeat_o ? act_duty[i] : 8'd0) :
                          (breathe_lvl < act_duty[i] ? breathe_lvl : act_duty[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_cnt     <= 32'(STEP_DIV - 1);
            hb_cnt       <= 32'(HB_HALF - 1);
            brth_cnt     <= 32'(BREATHE_DIV - 1);
            pwm_cnt      <= 8'd0;
            breathe_lvl  <= 8'd0;
            breathe_up   <= 1'b1;
            heartbeat_o  <= 1'b0;
            pwm_period_o <= 1'b0;
            led_o        <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                sh_mode[i]  <= M_OFF;
                sh_duty[i]  <= 8'd0;
                act_mode[i] <= M_OFF;
                act_duty[i] <= 8'd0;
            end
        end else begin
            step_cnt     <= step_tick ? 32'(STEP_DIV - 1) : step_cnt - 32'd1;
            pwm_cnt      <= step_tick ? pwm_cnt + 8'd1 : pwm_cnt;
            pwm_period_o <= boundary;
            hb_cnt       <= hb_cnt == 32'd0 ? 32'(HB_HALF - 1) : hb_cnt - 32'd1;
            if (hb_cnt == 32'd0)
                heartbeat_o <= ~heartbeat_o;
            // active loads read the pre-edge shadow, so a same-cycle write waits a period
            if (boundary) begin
                for (int i = 0; i < CH_NUM; i++) begin
                    act_mode[i] <= sh_mode[i];
                    act_duty[i] <= sh_duty[i];
                end
                brth_cnt <= brth_cnt == 32'd0 ? 32'(BREATHE_DIV - 1) : brth_cnt - 32'd1;
                if (brth_cnt == 32'd0) begin
                    if (breathe_up) begin
                        breathe_up  <= breathe_lvl != 8'hff;
                        breathe_lvl <= breathe_lvl == 8'hff ? 8'hfe : breathe_lvl + 8'd1;
                    end else begin
                        breathe_up  <= breathe_lvl == 8'd0;
                        breathe_lvl <= breathe_lvl == 8'd0 ? 8'd1 : breathe_lvl - 8'd1;
                    end
                end
            end
            if (cfg_we && 32'(cfg_ch) < CH_NUM) begin
                sh_mode[cfg_ch] <= cfg_mode;
                sh_duty[cfg_ch] <= cfg_duty;
            end
            for (int i = 0; i < CH_NUM; i++)
                led_o[i] <= pwm_cnt < duty_eff[i];
        end
    end
endmodule

// File: tb/tb_scr1_led_pwm_ctrl.sv
// tb_scr1_led_pwm_ctrl: period-level reference model pushes expected per-channel high
// counts at each predicted boundary; a monitor pops them at every pwm_period_o pulse.
module tb_scr1_led_pwm_ctrl;
    localparam int CH = 12;
    typedef logic [CH-1:0][7:0] rec_t;

    logic          clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0;
    logic [3:0]    cfg_ch = '0;
    logic [1:0]    cfg_mode = '0;
    logic [7:0]    cfg_duty = '0;
    logic [CH-1:0] led_o;
    logic          heartbeat_o, pwm_period_o;
    int            checks = 0, errors = 0;

    scr1_led_pwm_ctrl #(
        .CLK_FREQ(2560), .PWM_FREQ(10), .HB_HZ(1), .BREATHE_DIV(1), .CH_NUM(CH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .led_o(led_o),
        .heartbeat_o(heartbeat_o), .pwm_period_o(pwm_period_o)
    );

    always #5 clk = ~clk;

    // reference model, advanced on the same edges the DUT sees
    int       cyc = 0, lvl = 0;
    bit       hb_m = 0, up = 1;
    logic [1:0] sh_mode [CH];
    logic [1:0] ac_mode [CH];
    int       sh_duty [CH];
    int       ac_duty [CH];
    rec_t     sb[$];

    function automatic rec_t predict();
        rec_t r;
        for (int i = 0; i < CH; i++) begin
            int d;
            d = ac_mode[i] == 2'd0 ? 0 : ac_mode[i] == 2'd1 ? ac_duty[i] :
                ac_mode[i] == 2'd2 ? (hb_m ? ac_duty[i] : 0) :
                (lvl < ac_duty[i] ? lvl : ac_duty[i]);
            r[i] = 8'(d);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            cyc = 0; lvl = 0; up = 1; hb_m = 0;
            for (int i = 0; i < CH; i++) begin
                sh_mode[i] = 0; sh_duty[i] = 0; ac_mode[i] = 0; ac_duty[i] = 0;
            end
            sb.delete();
            sb.push_back('0);
        end else begin
            cyc++;
            if (cyc % 1280 == 0) hb_m = !hb_m;
            if (cyc % 256 == 0) begin
                for (int i = 0; i < CH; i++) begin
                    ac_mode[i] = sh_mode[i]; ac_duty[i] = sh_duty[i];
                end
                if (up) begin
                    if (lvl == 255) begin up = 0; lvl = 254; end else lvl++;
                end else begin
                    if (lvl == 0) begin up = 1; lvl = 1; end else lvl--;
                end
                sb.push_back(predict());
            end
            if (cfg_we && cfg_ch < CH) begin
                sh_mode[cfg_ch] = cfg_mode; sh_duty[cfg_ch] = int'(cfg_duty);
            end
        end
    end

    // monitor: LED window of a period runs from the cycle after one pulse through the next pulse
    int hi [CH];
    bit seen_lo [CH];
    bit shape_bad [CH];
    always @(negedge clk) begin
        if (!rst_n || cyc == 0) begin
            for (int i = 0; i < CH; i++) begin hi[i] = 0; seen_lo[i] = 0; shape_bad[i] = 0; end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (led_o[i]) begin hi[i]++; if (seen_lo[i]) shape_bad[i] = 1; end
                else seen_lo[i] = 1;
            end
            checks++;
            if (heartbeat_o !== hb_m) begin
                errors++;
                $display("FAIL heartbeat cyc=%0d: got %b expected %b", cyc, heartbeat_o, hb_m);
            end
            checks++;
            if (pwm_period_o !== (cyc % 256 == 0)) begin
                errors++;
                $display("FAIL pwm_period cyc=%0d: got %b expected %b", cyc, pwm_period_o, cyc % 256 == 0);
            end
            if (pwm_period_o) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard cyc=%0d: pulse with no expected period", cyc);
                end else begin
                    rec_t e;
                    e = sb.pop_front();
                    for (int i = 0; i < CH; i++) begin
                        checks++;
                        if (hi[i] != int'(e[i]) || shape_bad[i]) begin
                            errors++;
                            $display("FAIL period ch%0d cyc=%0d: high=%0d contiguous=%0d expected high=%0d contiguous=1",
                                     i, cyc, hi[i], !shape_bad[i], e[i]);
                        end
                    end
                end
                for (int i = 0; i < CH; i++) begin hi[i] = 0; seen_lo[i] = 0; shape_bad[i] = 0; end
            end
        end
    end

    task automatic write_cfg(input logic [3:0] ch, input logic [1:0] m, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1; cfg_ch = ch; cfg_mode = m; cfg_duty = d;
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic wait_pulse(output bit ok);
        ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            ok = pwm_period_o;
        end
    endtask

    task automatic count_window(input int ch, output int n, output bit first, output bit last);
        n = 0;
        for (int j = 0; j < 256; j++) begin
            @(negedge clk);
            if (led_o[ch]) n++;
            if (j == 0) first = led_o[ch];
            if (j == 255) last = led_o[ch];
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (5) @(negedge clk);
        checks++;
        if (led_o !== '0 || heartbeat_o !== 1'b0 || pwm_period_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: led=%h hb=%b period=%b expected all 0", led_o, heartbeat_o, pwm_period_o);
        end
        rst_n = 1;
    endtask

    task automatic test_heartbeat();
        int rise = -1, fall = -1, pulses = 0;
        for (int k = 0; k < 3000 && fall < 0; k++) begin
            @(negedge clk);
            if (pwm_period_o) pulses++;
            if (heartbeat_o && rise < 0) rise = cyc;
            if (!heartbeat_o && rise >= 0 && fall < 0) fall = cyc;
        end
        checks++;
        if (rise != 1280) begin errors++; $display("FAIL hb_rise: at %0d expected 1280", rise); end
        checks++;
        if (fall != 2560) begin errors++; $display("FAIL hb_fall: at %0d expected 2560", fall); end
        checks++;
        if (pulses != 10) begin errors++; $display("FAIL period_count: %0d expected 10", pulses); end
    endtask

    task automatic test_pwm();
        bit ok, f, l;
        int n;
        write_cfg(0, 1, 64);
        wait_pulse(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pwm_wait: no period pulse within bound"); end
        count_window(0, n, f, l);
        checks++;
        if (n != 64 || f !== 1'b1 || l !== 1'b0) begin
            errors++;
            $display("FAIL pwm64: high=%0d first=%b last=%b expected 64 1 0", n, f, l);
        end
    endtask

    task automatic test_update();
        bit ok, f, l;
        int n;
        repeat (100) @(negedge clk);
        write_cfg(0, 1, 200);
        wait_pulse(ok);
        count_window(0, n, f, l);
        checks++;
        if (!ok || n != 200) begin errors++; $display("FAIL mid_write: high=%0d expected 200", n); end
        do @(negedge clk); while (cyc % 256 != 255);
        cfg_we = 1; cfg_ch = 0; cfg_mode = 1; cfg_duty = 30;
        @(negedge clk);
        cfg_we = 0;
        count_window(0, n, f, l);
        checks++;
        if (n != 200) begin errors++; $display("FAIL boundary_write_old: high=%0d expected 200", n); end
        count_window(0, n, f, l);
        checks++;
        if (n != 30) begin errors++; $display("FAIL boundary_write_new: high=%0d expected 30", n); end
    endtask

    task automatic test_duty_edges();
        bit ok, f, l;
        int n, bad;
        write_cfg(0, 1, 0);
        wait_pulse(ok);
        n = 0;
        repeat (1024) begin @(negedge clk); if (led_o[0]) n++; end
        checks++;
        if (!ok || n != 0) begin errors++; $display("FAIL duty0: high=%0d expected 0", n); end
        write_cfg(0, 1, 255);
        wait_pulse(ok);
        count_window(0, n, f, l);
        checks++;
        if (!ok || n != 255 || f !== 1'b1 || l !== 1'b0) begin
            errors++;
            $display("FAIL duty255: high=%0d first=%b last=%b expected 255 1 0", n, f, l);
        end
        write_cfg(4'd12, 1, 77);
        wait_pulse(ok);
        n = 0; bad = 0;
        repeat (256) begin
            @(negedge clk);
            if (led_o[0]) n++;
            if (led_o[CH-1:1] != '0) bad++;
        end
        checks++;
        if (!ok || n != 255 || bad != 0) begin
            errors++;
            $display("FAIL bad_channel_write: ch0 high=%0d others_high=%0d expected 255 0", n, bad);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        repeat (100) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        checks++;
        if (led_o !== '0 || pwm_period_o !== 1'b0 || heartbeat_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: led=%h period=%b hb=%b expected 0", led_o, pwm_period_o, heartbeat_o);
        end
        @(negedge clk);
        rst_n = 1;
        wait_pulse(ok);
        checks++;
        if (!ok || cyc != 256) begin errors++; $display("FAIL restart_period: pulse at %0d expected 256", cyc); end
    endtask

    task automatic test_blink();
        int n = 0, bad = 0;
        write_cfg(5, 2, 128);
        while (cyc < 3300) begin
            @(negedge clk);
            if (led_o[5]) n++;
            if (!heartbeat_o && led_o[5]) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL blink_off: %0d high cycles with hb=0 expected 0", bad); end
        checks++;
        if (n != 640) begin errors++; $display("FAIL blink_on: high=%0d expected 640", n); end
    endtask

    task automatic test_breathe();
        bit ok, f, l;
        int n;
        write_cfg(3, 3, 255);
        wait_pulse(ok);
        count_window(3, n, f, l);
        checks++;
        if (!ok || n != 13) begin errors++; $display("FAIL breathe_ramp: high=%0d expected 13", n); end
        while (cyc < 130 * 256 + 50) @(negedge clk);
        write_cfg(3, 3, 100);
        wait_pulse(ok);
        count_window(3, n, f, l);
        checks++;
        if (!ok || n != 100) begin errors++; $display("FAIL breathe_cap: high=%0d expected 100", n); end
        while (cyc < 200 * 256 + 50) @(negedge clk);
        write_cfg(3, 3, 255);
        while (cyc != 255 * 256) @(negedge clk);
        for (int p = 255; p >= 253; p--) begin
            count_window(3, n, f, l);
            checks++;
            if (n != p) begin errors++; $display("FAIL breathe_peak: high=%0d expected %0d", n, p); end
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_heartbeat();
        test_pwm();
        test_update();
        test_duty_edges();
        test_mid_reset();
        test_blink();
        test_breathe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
